// File: rtl/seg7_pkg.sv
// Shared symbol codes, active-low GFEDCBA patterns and the expected message for
// the seven-segment scroller and its receive-side decoder.
package seg7_pkg;

    localparam logic [3:0] SYM_H     = 4'd0;
    localparam logic [3:0] SYM_E     = 4'd1;
    localparam logic [3:0] SYM_L     = 4'd2;
    localparam logic [3:0] SYM_O     = 4'd3;
    localparam logic [3:0] SYM_A     = 4'd4;
    localparam logic [3:0] SYM_S     = 4'd5;
    localparam logic [3:0] SYM_I     = 4'd6;
    localparam logic [3:0] SYM_C     = 4'd7;
    localparam logic [3:0] SYM_BLANK = 4'd8;
    localparam logic [3:0] SYM_BAD   = 4'd15;

    localparam logic [6:0] PAT_H     = 7'b0001001;
    localparam logic [6:0] PAT_E     = 7'b0000110;
    localparam logic [6:0] PAT_L     = 7'b1000111;
    localparam logic [6:0] PAT_O     = 7'b1000000;
    localparam logic [6:0] PAT_A     = 7'b0001000;
    localparam logic [6:0] PAT_S     = 7'b0010010;
    localparam logic [6:0] PAT_I     = 7'b1001111;
    localparam logic [6:0] PAT_C     = 7'b1000110;
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

    localparam int MSG_LEN = 10;

    // Entry 0 is the first symbol of "HELLO ASIC".
    localparam logic [MSG_LEN-1:0][3:0] MSG_EXPECTED = {
        SYM_C, SYM_I, SYM_S, SYM_A, SYM_BLANK,
        SYM_O, SYM_L, SYM_L, SYM_E, SYM_H
    };

    typedef enum logic [3:0] {
        M_H     = 4'd0,
        M_E     = 4'd1,
        M_L1    = 4'd2,
        M_L2    = 4'd3,
        M_O     = 4'd4,
        M_BLANK = 4'd5,
        M_A     = 4'd6,
        M_S     = 4'd7,
        M_I     = 4'd8,
        M_C     = 4'd9
    } match_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup from an active-low GFEDCBA pattern to a symbol code;
// unknown patterns map to SYM_BAD.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_code
);

    always_comb begin
        o_code = SYM_BAD;
        case (i_pattern)
            PAT_H:     o_code = SYM_H;
            PAT_E:     o_code = SYM_E;
            PAT_L:     o_code = SYM_L;
            PAT_O:     o_code = SYM_O;
            PAT_A:     o_code = SYM_A;
            PAT_S:     o_code = SYM_S;
            PAT_I:     o_code = SYM_I;
            PAT_C:     o_code = SYM_C;
            PAT_BLANK: o_code = SYM_BLANK;
            default:   o_code = SYM_BAD;
        endcase
    end

endmodule

// File: rtl/seg7_message_decoder.sv
// Glitch-filtered seven-segment receiver: emits one symbol per stable display
// period and flags each complete "HELLO ASIC" message.
//
// state   | meaning
// M_H     | waiting for H (idx 0)
// M_E     | H seen, waiting for E
// M_L1    | HE seen, waiting for first L
// M_L2    | HEL seen, waiting for second L
// M_O     | HELL seen, waiting for O
// M_BLANK | HELLO seen, waiting for blank
// M_A     | waiting for A
// M_S     | waiting for S
// M_I     | waiting for I
// M_C     | waiting for final C; match on arrival
module seg7_message_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYMBOL_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seg_in,
    output logic [3:0] sym_code,
    output logic       sym_valid,
    output logic       sym_err,
    output logic       msg_match,
    output logic [3:0] msg_count
);

    localparam int RUN_MAX = STABLE_CYCLES + SYMBOL_CYCLES;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    logic [7:0]       r_sync1;
    logic [7:0]       r_sync2;
    logic [7:0]       r_prev;
    logic [RUN_W-1:0] r_run;
    match_state_t     r_state;

    logic [RUN_W-1:0] w_run_next;
    logic [RUN_W-1:0] w_run_load;
    logic             w_emit;
    logic [3:0]       w_code;
    logic [3:0]       w_expected;

    seg7_pattern_decode u_decode (
        .i_pattern (r_sync2[6:0]),
        .o_code    (w_code)
    );

    // DP is forced high so it never breaks a run.
    always_comb begin
        w_run_next = RUN_W'(1);
        if ((r_sync2 | 8'h80) == r_prev) begin
            w_run_next = r_run + 1'b1;
        end
    end

    // The run reloads to STABLE after a repeat emission, so repeats fall every SYMBOL edges.
    assign w_emit     = (w_run_next == RUN_W'(STABLE_CYCLES)) || (w_run_next == RUN_W'(RUN_MAX));
    assign w_run_load = (w_run_next == RUN_W'(RUN_MAX)) ? RUN_W'(STABLE_CYCLES) : w_run_next;
    assign w_expected = MSG_EXPECTED[r_state];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 8'hFF;
            r_sync2   <= 8'hFF;
            r_prev    <= 8'hFF;
            r_run     <= '0;
            r_state   <= M_H;
            sym_code  <= 4'd0;
            sym_valid <= 1'b0;
            sym_err   <= 1'b0;
            msg_match <= 1'b0;
            msg_count <= 4'd0;
        end else begin
            r_sync1   <= seg_in;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2 | 8'h80;
            r_run     <= w_run_load;
            sym_valid <= w_emit;
            sym_err   <= w_emit && (w_code == SYM_BAD);
            msg_match <= 1'b0;
            if (w_emit) begin
                sym_code <= w_code;
                if (w_code == SYM_BAD) begin
                    r_state <= M_H;
                end else if (w_code == w_expected) begin
                    if (r_state == M_C) begin
                        msg_match <= 1'b1;
                        r_state   <= M_H;
                        if (msg_count != 4'hF) begin
                            msg_count <= msg_count + 4'd1;
                        end
                    end else begin
                        r_state <= match_state_t'(r_state + 4'd1);
                    end
                end else if (w_code == SYM_H) begin
                    r_state <= M_E;
                end else begin
                    r_state <= M_H;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_message_decoder.sv
// Bench for seg7_message_decoder: a stream-history model checked every cycle,
// plus literal expectations on emission timing and message counts.
module tb_seg7_message_decoder;

    logic       clk;
    logic       reset;
    logic [7:0] seg_in;
    logic [3:0] sym_code;
    logic       sym_valid;
    logic       sym_err;
    logic       msg_match;
    logic [3:0] msg_count;

    seg7_message_decoder #(.STABLE_CYCLES(4), .SYMBOL_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg_in    (seg_in),
        .sym_code  (sym_code),
        .sym_valid (sym_valid),
        .sym_err   (sym_err),
        .msg_match (msg_match),
        .msg_count (msg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    localparam logic [7:0] P_H = 8'h89, P_E = 8'h86, P_L = 8'hC7, P_O = 8'hC0;
    localparam logic [7:0] P_A = 8'h88, P_S = 8'h92, P_I = 8'hCF, P_C = 8'hC6;
    localparam logic [7:0] P_BL = 8'hFF;

    int exp_msg [10] = '{0, 1, 2, 2, 3, 8, 4, 5, 6, 7};

    function automatic logic [3:0] ref_decode(input logic [6:0] p);
        case (p)
            7'h09: return 4'd0;
            7'h06: return 4'd1;
            7'h47: return 4'd2;
            7'h40: return 4'd3;
            7'h08: return 4'd4;
            7'h12: return 4'd5;
            7'h4F: return 4'd6;
            7'h46: return 4'd7;
            7'h7F: return 4'd8;
            default: return 4'd15;
        endcase
    endfunction

    // Model: the decoder sees seg_in two edges late; emissions depend on the
    // length of the trailing run of identical samples seen since reset.
    logic [6:0] m_p1, m_p2, m_cur;
    logic [6:0] m_hist [$];
    int         m_idx, m_len, m_code;
    logic       m_emit;
    int         e_code, e_count;
    logic       e_valid, e_err, e_match;

    int         ecount = 0;
    int         base = 0;
    int         valid_edges [$];
    int         n_match = 0, n_err = 0, n_code1 = 0, match_code = -1;

    always @(posedge clk) begin
        ecount++;
        if (reset) begin
            m_p1 = 7'h7F; m_p2 = 7'h7F;
            m_hist.delete();
            m_idx = 0;
            e_code = 0; e_valid = 0; e_err = 0; e_match = 0; e_count = 0;
        end else begin
            m_cur = m_p2;
            m_p2  = m_p1;
            m_p1  = seg_in[6:0];
            m_hist.push_back(m_cur);
            m_len = 0;
            for (int i = m_hist.size() - 1; i >= 0; i--) begin
                if (m_hist[i] != m_cur) break;
                m_len++;
            end
            m_emit  = (m_len == 4) || (m_len > 4 && ((m_len - 4) % 16) == 0);
            e_valid = m_emit;
            e_err   = 1'b0;
            e_match = 1'b0;
            if (m_emit) begin
                m_code = ref_decode(m_cur);
                e_code = m_code;
                e_err  = (m_code == 15);
                if (m_code == 15) m_idx = 0;
                else if (m_code == exp_msg[m_idx]) begin
                    if (m_idx == 9) begin
                        e_match = 1'b1;
                        if (e_count < 15) e_count++;
                        m_idx = 0;
                    end else m_idx++;
                end else m_idx = (m_code == 0) ? 1 : 0;
            end
        end
        #1;
        chk("sym_valid", int'(sym_valid), int'(e_valid));
        chk("sym_code",  int'(sym_code),  e_code);
        chk("sym_err",   int'(sym_err),   int'(e_err));
        chk("msg_match", int'(msg_match), int'(e_match));
        chk("msg_count", int'(msg_count), e_count);
        if (sym_valid) begin
            valid_edges.push_back(ecount - base);
            if (sym_code == 4'd1) n_code1++;
        end
        if (sym_err) n_err++;
        if (msg_match) begin
            n_match++;
            match_code = int'(sym_code);
        end
    end

    task automatic hold(input logic [7:0] p, input int n);
        seg_in = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_msg();
        hold(P_H, 16); hold(P_E, 16); hold(P_L, 16); hold(P_L, 16); hold(P_O, 16);
        hold(P_BL, 16); hold(P_A, 16); hold(P_S, 16); hold(P_I, 16); hold(P_C, 16);
    endtask

    task automatic mark();
        base = ecount;
        valid_edges.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        seg_in = P_BL;
        repeat (2) @(negedge clk);
        chk("reset_valid", int'(sym_valid), 0);
        chk("reset_count", int'(msg_count), 0);
        reset = 1'b0;

        // Steady H: emissions after edges 6, 22, 38.
        mark();
        hold(P_H, 40);
        chk("h_emissions", valid_edges.size(), 3);
        if (valid_edges.size() == 3) begin
            chk("h_edge0", valid_edges[0], 6);
            chk("h_edge1", valid_edges[1], 22);
            chk("h_edge2", valid_edges[2], 38);
        end
        chk("h_no_err", n_err, 0);

        // 3-cycle E glitch inside blank must not emit E.
        n_code1 = 0;
        hold(P_BL, 20); hold(P_E, 3); hold(P_BL, 20);
        chk("glitch_no_e", n_code1, 0);

        n_match = 0;
        send_msg();
        hold(P_BL, 20);
        chk("msg1_matches", n_match, 1);
        chk("msg1_code_c", match_code, 7);
        chk("msg1_count", int'(msg_count), 1);

        // Unknown pattern after HEL aborts the message.
        n_match = 0; n_err = 0;
        hold(P_H, 16); hold(P_E, 16); hold(P_L, 16); hold(8'h00, 6);
        hold(P_L, 16); hold(P_O, 16); hold(P_BL, 16); hold(P_A, 16);
        hold(P_S, 16); hold(P_I, 16); hold(P_C, 16); hold(P_BL, 20);
        chk("bad_err_pulses", n_err, 1);
        chk("bad_no_match", n_match, 0);
        chk("bad_count", int'(msg_count), 1);

        // Restart on H inside the message.
        n_match = 0;
        hold(P_H, 16); hold(P_E, 16);
        send_msg();
        hold(P_BL, 20);
        chk("restart_matches", n_match, 1);
        chk("restart_count", int'(msg_count), 2);

        // Reset mid-run: full 6 edges needed again.
        hold(P_H, 10);
        reset = 1'b1;
        hold(P_H, 1);
        chk("midrun_valid", int'(sym_valid), 0);
        chk("midrun_count", int'(msg_count), 0);
        reset = 1'b0;
        mark();
        hold(P_H, 10);
        chk("midrun_emissions", valid_edges.size(), 1);
        if (valid_edges.size() == 1) chk("midrun_edge", valid_edges[0], 6);

        // Reset mid-message discards the partial match.
        n_match = 0;
        hold(P_BL, 20);
        hold(P_H, 16); hold(P_E, 16); hold(P_L, 16);
        reset = 1'b1;
        hold(P_L, 1);
        reset = 1'b0;
        hold(P_L, 16); hold(P_O, 16); hold(P_BL, 16); hold(P_A, 16);
        hold(P_S, 16); hold(P_I, 16); hold(P_C, 16); hold(P_BL, 20);
        chk("midmsg_no_match", n_match, 0);
        chk("midmsg_count", int'(msg_count), 0);

        // Sixteen messages saturate the counter at 15.
        n_match = 0;
        for (int k = 0; k < 16; k++) send_msg();
        hold(P_BL, 20);
        chk("sat_matches", n_match, 16);
        chk("sat_count", int'(msg_count), 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
